// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath constants: operand widths common to the 8x8
// multiplier and the 16/8 divider, plus the divider's FSM encoding.
package arith_pkg;

    localparam int DIV_DW = 16;
    localparam int DIV_VW = 8;
    localparam int DIV_CW = $clog2(DIV_DW);

    typedef logic [1:0] div_state_t;

    localparam div_state_t IDLE = 2'd0;
    localparam div_state_t CALC = 2'd1;
    localparam div_state_t DONE = 2'd2;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor, and keep the difference only when it did not go negative.
module div_step
    import arith_pkg::*;
#(
    parameter int VW = DIV_VW
) (
    input  logic [VW-1:0] rem_i,
    input  logic          bit_i,
    input  logic [VW-1:0] divisor_i,
    output logic [VW-1:0] rem_o,
    output logic          qbit_o
);

    logic [VW:0]   trial;
    logic [VW-1:0] diff;

    // Any accepted result is below the divisor, so a VW-bit difference is exact.
    assign trial  = {rem_i, bit_i};
    assign qbit_o = (trial >= {1'b0, divisor_i});
    assign diff   = trial[VW-1:0] - divisor_i;
    assign rem_o  = qbit_o ? diff : trial[VW-1:0];

endmodule

// File: rtl/seq_div_16by8.sv
// Multi-cycle restoring divider, one quotient bit per clock, with a
// start/busy/done handshake; results are published only on the done pulse.
module seq_div_16by8
    import arith_pkg::*;
#(
    parameter int DW = DIV_DW,
    parameter int VW = DIV_VW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [DW-1:0] dividend_i,
    input  logic [VW-1:0] divisor_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [DW-1:0] quotient_o,
    output logic [VW-1:0] remainder_o,
    output logic          div_by_zero_o
);

    localparam int CW = $clog2(DW);

    div_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] quo_q, quo_d;
    logic [VW-1:0] rem_q, rem_d;
    logic [VW-1:0] divisor_q, divisor_d;
    logic          dbz_q, dbz_d;
    logic          done_q, done_d;
    logic [DW-1:0] quotient_q, quotient_d;
    logic [VW-1:0] remainder_q, remainder_d;
    logic          divByZero_q, divByZero_d;

    logic [VW-1:0] stepRem;
    logic          stepBit;

    div_step #(.VW(VW)) u_step (
        .rem_i     (rem_q),
        .bit_i     (quo_q[DW-1]),
        .divisor_i (divisor_q),
        .rem_o     (stepRem),
        .qbit_o    (stepBit)
    );

    // A start in the done-pulse cycle is refused, so back-to-back operations
    // always leave at least one visible idle cycle after done.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        divisor_d   = divisor_q;
        dbz_d       = dbz_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        divByZero_d = divByZero_q;
        case (state_q)
            IDLE: begin
                if (start_i && !done_q) begin
                    if (divisor_i != '0) begin
                        divisor_d = divisor_i;
                        quo_d     = dividend_i;
                        rem_d     = '0;
                        cnt_d     = CW'(DW - 1);
                        dbz_d     = 1'b0;
                        state_d   = CALC;
                    end else begin
                        quo_d   = '1;
                        rem_d   = dividend_i[VW-1:0];
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            CALC: begin
                rem_d = stepRem;
                quo_d = {quo_q[DW-2:0], stepBit};
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                quotient_d  = quo_q;
                remainder_d = rem_q;
                divByZero_d = dbz_q;
                done_d      = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            divisor_q   <= '0;
            dbz_q       <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            divByZero_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            divisor_q   <= divisor_d;
            dbz_q       <= dbz_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            divByZero_q <= divByZero_d;
        end
    end

    assign busy_o        = (state_q != IDLE);
    assign done_o        = done_q;
    assign quotient_o    = quotient_q;
    assign remainder_o   = remainder_q;
    assign div_by_zero_o = divByZero_q;

endmodule
